// File: rtl/uart_rx_framer_if.sv
// Write-side link from the UART receive framer into the RX FIFO.
interface uart_rx_framer_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic                    fifo_write;
  logic [PAYLOAD_BITS-1:0] fifo_write_data;
  logic                    fifo_full;

  modport master (
    output fifo_write,
    output fifo_write_data,
    input  fifo_full
  );

  modport slave (
    input  fifo_write,
    input  fifo_write_data,
    output fifo_full
  );
endinterface

// File: rtl/uart_rx_framer.sv
// Receive-side UART deserializer: synchronizes rxd, frames LSB-first bytes and
// pushes good bytes into the RX FIFO, with sticky framing/overflow status.
module uart_rx_framer #(
  parameter int unsigned CLK_FREQ     = 25000000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic             clear_errors,
  uart_rx_framer_if.master fifo,
  output logic             busy,
  output logic             frame_error,
  output logic             overflow
);

  localparam int unsigned CPB   = CLK_FREQ / BIT_RATE;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = $clog2(PAYLOAD_BITS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    wr_q, wr_d;
  logic                    busy_q, busy_d;
  logic                    fe_q, fe_d;
  logic                    ov_q, ov_d;
  logic                    fe_set, ov_set;
  logic                    rx_meta, rxs;

  // Two-flop synchronizer; only rxs feeds the framer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state: the cycle counter restarts at every sample point so each
  // sample lands one bit period after the previous one, starting mid start-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    fe_set  = 1'b0;
    ov_set  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = PAYLOAD_BITS'({rxs, shift_q} >> 1);
          if (idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          if (!rxs) begin
            fe_set  = 1'b1;
            state_d = BREAK;
          end else if (fifo.fifo_full) begin
            ov_set  = 1'b1;
            state_d = IDLE;
          end else begin
            wr_d    = 1'b1;
            data_d  = shift_q;
            state_d = IDLE;
          end
        end
      end

      BREAK: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    // A set event in the same cycle as clear_errors leaves the flag set.
    fe_d   = fe_set | (fe_q & ~clear_errors);
    ov_d   = ov_set | (ov_q & ~clear_errors);
  end

  assign fifo.fifo_write      = wr_q;
  assign fifo.fifo_write_data = data_q;
  assign busy                 = busy_q;
  assign frame_error          = fe_q;
  assign overflow             = ov_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed frame table, hand-built corner sequences and
// random traffic, all compared against a frame-level reference model.
module tb_uart_rx_framer;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BIT_RATE = 100000;
  localparam int unsigned PB_U     = 8;
  localparam int PB    = 8;
  localparam int CPB   = 10;
  localparam int HALF  = 5;
  localparam int FRAME = (PB + 2) * CPB;
  localparam int WR_AT = 2 + HALF + (PB + 1) * CPB + 1;
  localparam int N     = 5000;

  logic clk = 1'b0;
  logic reset, rxd, clear_errors, busy, frame_error, overflow;

  uart_rx_framer_if #(.PAYLOAD_BITS(PB_U)) fifo_bus ();

  uart_rx_framer #(
    .CLK_FREQ    (CLK_FREQ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PB_U)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .clear_errors(clear_errors),
    .fifo        (fifo_bus),
    .busy        (busy),
    .frame_error (frame_error),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         stop_bit;
    bit         full;
    int         low_after;
    int         gap;
    bit         exp_wr;
    bit         exp_fe;
    bit         exp_ov;
  } vec_t;

  vec_t tbl [6];
  int   tbl_start [6];

  // Stimulus per cycle index, reference expectations, and observed outputs.
  bit         r_a [N];
  bit         f_a [N];
  bit         c_a [N];
  bit         rst_a [N];
  bit         wr_ev [N];
  bit         fe_ev [N];
  bit         ov_ev [N];
  logic [7:0] byte_ev [N];
  logic       e_busy [N];
  logic       e_wr [N];
  logic       e_fe [N];
  logic       e_ov [N];
  logic [7:0] e_data [N];
  logic       a_busy [N];
  logic       a_wr [N];
  logic       a_fe [N];
  logic       a_ov [N];
  logic [7:0] a_data [N];

  int pos;
  int checks;
  int errors;

  task automatic check(input string name, input int at, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, at, act, exp);
    end
  endtask

  task automatic put_idle(input int n);
    pos += n;
  endtask

  task automatic put_low(input int n);
    for (int j = 0; j < n; j++) r_a[pos + j] = 1'b0;
    pos += n;
  endtask

  task automatic put_frame(input logic [7:0] d, input bit stop, input bit full);
    for (int j = 0; j < FRAME; j++) begin
      int b;
      b = j / CPB;
      r_a[pos + j] = (b == 0) ? 1'b0 : (b <= PB) ? d[b - 1] : stop;
    end
    f_a[pos + WR_AT - 1] = full;
    pos += FRAME;
  endtask

  // Line value as seen by the receiver two cycles after it is driven.
  function automatic bit rxs_at(input int k);
    if (k < 2) return 1'b1;
    if (rst_a[k - 1] || rst_a[k - 2]) return 1'b1;
    return r_a[k - 2];
  endfunction

  function automatic int writes_in(input int a, input int b);
    int n;
    n = 0;
    for (int j = a; j <= b; j++) n += (a_wr[j] === 1'b1) ? 1 : 0;
    return n;
  endfunction

  function automatic int first_write(input int a, input int b);
    for (int j = a; j <= b; j++) if (a_wr[j] === 1'b1) return j;
    return -1;
  endfunction

  // Frame-level decode from sample times: start at t0+HALF, bit i at
  // t0+HALF+(i+1)*CPB, stop at ts; then sticky/hold rules applied per cycle.
  task automatic build_model();
    int k, t0, ts, e, kr, oc, endi;
    logic [7:0] b;
    k = 0;
    while (k < N) begin
      if (rst_a[k] || rxs_at(k)) begin
        k++;
        continue;
      end
      t0 = k;
      ts = t0 + HALF + (PB + 1) * CPB;
      if (ts + 1 >= N) break;
      b = '0;
      if (rxs_at(t0 + HALF)) begin
        oc = 0;
        e  = t0 + HALF;
      end else begin
        for (int i = 0; i < PB; i++) b[i] = rxs_at(t0 + HALF + (i + 1) * CPB);
        if (!rxs_at(ts)) begin
          oc = 3;
          e  = ts + 1;
          while (e < N - 1 && !rxs_at(e)) e++;
        end else begin
          oc = f_a[ts] ? 2 : 1;
          e  = ts;
        end
      end
      kr = -1;
      for (int j = t0; j <= e; j++) begin
        if (rst_a[j]) begin
          kr = j;
          break;
        end
      end
      endi = (kr >= 0) ? kr : e;
      if (kr < 0 || (oc == 3 && kr > ts)) begin
        if (oc == 1) begin
          wr_ev[ts]   = 1'b1;
          byte_ev[ts] = b;
        end
        if (oc == 2) ov_ev[ts] = 1'b1;
        if (oc == 3) fe_ev[ts] = 1'b1;
      end
      for (int s = t0 + 1; s <= endi; s++) e_busy[s] = 1'b1;
      k = endi + 1;
    end
    e_wr[0] = 1'b0; e_data[0] = '0; e_fe[0] = 1'b0; e_ov[0] = 1'b0;
    for (int j = 0; j < N - 1; j++) begin
      e_wr[j + 1]   = wr_ev[j];
      e_data[j + 1] = rst_a[j] ? 8'h00 : wr_ev[j] ? byte_ev[j] : e_data[j];
      e_fe[j + 1]   = rst_a[j] ? 1'b0 : fe_ev[j] ? 1'b1 : c_a[j] ? 1'b0 : e_fe[j];
      e_ov[j + 1]   = rst_a[j] ? 1'b0 : ov_ev[j] ? 1'b1 : c_a[j] ? 1'b0 : e_ov[j];
    end
  endtask

  initial begin
    int clr_at, ov1_s, ov2_s, gl_s, rs_s, r55_s, s, w, hh;
    logic [7:0] d;
    logic [7:0] v55;
    bit stp;

    checks = 0;
    errors = 0;
    for (int k = 0; k < N; k++) begin
      r_a[k] = 1'b1;
      e_busy[k] = 1'b0;
    end
    rst_a[0] = 1'b1; rst_a[1] = 1'b1; rst_a[2] = 1'b1;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 0,  20, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b0, 0,  0,  1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b0, 0,  20, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h77, 1'b1, 1'b1, 0,  20, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h3C, 1'b0, 1'b0, 50, 20, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{8'h11, 1'b1, 1'b0, 0,  20, 1'b1, 1'b1, 1'b1};

    pos = 10;
    for (int i = 0; i < 6; i++) begin
      tbl_start[i] = pos;
      put_frame(tbl[i].data, tbl[i].stop_bit, tbl[i].full);
      put_low(tbl[i].low_after);
      put_idle(tbl[i].gap);
    end

    clr_at = pos; c_a[pos] = 1'b1; put_idle(10);
    ov1_s = pos; put_frame(8'h77, 1'b1, 1'b1); put_idle(20);
    ov2_s = pos; put_frame(8'h77, 1'b1, 1'b1); c_a[ov2_s + WR_AT - 1] = 1'b1; put_idle(20);
    gl_s = pos; put_low(3); put_idle(30);
    // Partial 0x55 cut off by reset in the middle of data bit 4.
    rs_s = pos; v55 = 8'h55; r_a[rs_s] = 1'b0;
    for (int j = CPB; j < 5 * CPB + HALF; j++) r_a[rs_s + j] = v55[j / CPB - 1];
    rst_a[rs_s + 5 * CPB + HALF] = 1'b1;
    pos += 80;
    r55_s = pos; put_frame(8'h55, 1'b1, 1'b0); put_idle(30);

    while (pos < N - 400) begin
      s   = pos;
      d   = 8'($urandom);
      stp = ($urandom_range(7) != 0);
      put_frame(d, stp, 1'b0);
      for (int j = 0; j < FRAME; j++) f_a[s + j] = ($urandom_range(3) == 0);
      if ($urandom_range(5) == 0) c_a[s + int'($urandom_range(FRAME - 1))] = 1'b1;
      if ($urandom_range(9) == 0) rst_a[s + int'($urandom_range(FRAME - 1))] = 1'b1;
      if (!stp) put_low(int'($urandom_range(40)));
      if ($urandom_range(5) == 0) begin
        put_idle(1 + int'($urandom_range(4)));
        put_low(1 + int'($urandom_range(3)));
      end
      put_idle((stp && $urandom_range(1) == 0) ? 0 : 1 + int'($urandom_range(20)));
    end

    build_model();

    reset = 1'b1; rxd = 1'b1; clear_errors = 1'b0; fifo_bus.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      a_busy[k] = busy;
      a_wr[k]   = fifo_bus.fifo_write;
      a_fe[k]   = frame_error;
      a_ov[k]   = overflow;
      a_data[k] = fifo_bus.fifo_write_data;
      reset               = rst_a[k];
      rxd                 = r_a[k];
      fifo_bus.fifo_full  = f_a[k];
      clear_errors        = c_a[k];
    end

    check("reset_state", 3, 32'({a_busy[3], a_wr[3], a_fe[3], a_ov[3], a_data[3]}), 32'h0);

    for (int i = 0; i < 6; i++) begin
      s = tbl_start[i];
      w = s + WR_AT;
      check("tbl_write_count", s, 32'(writes_in(s, s + FRAME - 1 + tbl[i].low_after)),
            32'(tbl[i].exp_wr));
      check("tbl_write_pulse", w, 32'(a_wr[w]), 32'(tbl[i].exp_wr));
      if (tbl[i].exp_wr) check("tbl_data", w, 32'(a_data[w]), 32'(tbl[i].data));
      check("tbl_frame_error", w, 32'(a_fe[w]), 32'(tbl[i].exp_fe));
      check("tbl_overflow", w, 32'(a_ov[w]), 32'(tbl[i].exp_ov));
    end
    check("b2b_spacing", tbl_start[2],
          32'(first_write(tbl_start[2], tbl_start[2] + FRAME - 1) -
              first_write(tbl_start[1], tbl_start[1] + FRAME - 1)), 32'd100);
    hh = tbl_start[4] + FRAME + 50;
    check("break_busy_held", hh + 2, 32'(a_busy[hh + 2]), 32'd1);
    check("break_busy_release", hh + 3, 32'(a_busy[hh + 3]), 32'd0);

    check("clear_pre_fe", clr_at, 32'(a_fe[clr_at]), 32'd1);
    check("clear_fe", clr_at + 1, 32'(a_fe[clr_at + 1]), 32'd0);
    check("clear_ov", clr_at + 1, 32'(a_ov[clr_at + 1]), 32'd0);
    check("ov_first", ov1_s + WR_AT, 32'(a_ov[ov1_s + WR_AT]), 32'd1);
    check("ov_set_beats_clear", ov2_s + WR_AT, 32'(a_ov[ov2_s + WR_AT]), 32'd1);
    check("ov_no_write", ov1_s, 32'(writes_in(ov1_s, ov2_s + FRAME)), 32'd0);

    check("glitch_busy", gl_s + 3, 32'(a_busy[gl_s + 3]), 32'd1);
    check("glitch_idle", gl_s + 8, 32'(a_busy[gl_s + 8]), 32'd0);
    check("glitch_no_write", gl_s, 32'(writes_in(gl_s, gl_s + 32)), 32'd0);
    check("glitch_no_fe", gl_s + 32, 32'(a_fe[gl_s + 32]), 32'd0);

    check("rst_busy_before", rs_s + 55, 32'(a_busy[rs_s + 55]), 32'd1);
    check("rst_busy_after", rs_s + 56, 32'(a_busy[rs_s + 56]), 32'd0);
    check("rst_flags", rs_s + 56, 32'({a_fe[rs_s + 56], a_ov[rs_s + 56]}), 32'd0);
    check("rst_data", rs_s + 56, 32'(a_data[rs_s + 56]), 32'd0);
    check("rst_no_write", rs_s, 32'(writes_in(rs_s, rs_s + 79)), 32'd0);
    check("post_rst_write", r55_s + WR_AT, 32'(a_wr[r55_s + WR_AT]), 32'd1);
    check("post_rst_data", r55_s + WR_AT, 32'(a_data[r55_s + WR_AT]), 32'h55);

    for (int k = 0; k < N; k++) begin
      check("cycle_outputs", k,
            32'({a_busy[k], a_wr[k], a_fe[k], a_ov[k], a_data[k]}),
            32'({e_busy[k], e_wr[k], e_fe[k], e_ov[k], e_data[k]}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
